// File: rtl/nios_timer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nios_timer_seq_pkg
//  Purpose  : Shared types and constants for the interval-timer sequencer.
//             Holds the FSM state enum, the timer s1 register map, the
//             control words and a small helper that builds a bus write beat.
//  Revision : 1.0  initial release
// ============================================================================
package nios_timer_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_WR_CTL   = 4'd3,
        ST_WAIT_IRQ = 4'd4,
        ST_RD_ADDR  = 4'd5,
        ST_RD_CHK   = 4'd6,
        ST_WR_CLR   = 4'd7,
        ST_NEXT     = 4'd8,
        ST_ABT_STOP = 4'd9,
        ST_ABT_CLR  = 4'd10
    } seq_state_t;

    // Timer s1 register map
    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    // Control words: {STOP, START, CONT, ITO}
    localparam logic [15:0] CTL_START_ITO = 16'h0005;
    localparam logic [15:0] CTL_STOP      = 16'h0008;

    // One cycle of s1 bus drive
    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } tmr_bus_t;

    localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'd0};

    function automatic tmr_bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        tmr_bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.wdata   = data;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios_timer_sequencer_table.sv
`default_nettype none
// ============================================================================
//  Module   : nios_timer_seq_table
//  Purpose  : DEPTH x 32 period table. One synchronous write port, one
//             asynchronous read port. Contents are not reset.
//  Ports    : clk      - clock
//             i_we     - write enable
//             i_waddr  - write index
//             i_wdata  - period value to store
//             i_raddr  - read index
//             o_rdata  - entry at i_raddr (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module nios_timer_seq_table #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/nios_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : nios_timer_sequencer
//  Purpose  : Avalon-MM master that walks a table of one-shot periods through
//             the interval timer's s1 port: load period, start with IRQ,
//             wait for irq, confirm TO, clear status, advance.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             cfg_we/cfg_addr/cfg_data - period table write (idle only)
//             seq_len, loop_en       - run length / wrap, sampled on start
//             start, abort           - 1-cycle control pulses
//             tmr_*                  - timer s1 master interface
//             busy, step_idx         - run status
//             step_done, seq_done    - completion pulses
//             err                    - sticky TO-missing flag
//  Revision : 1.0  initial release
// ============================================================================
module nios_timer_sequencer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [31:0]      cfg_data,
    input  logic [IDX_W:0]   seq_len,
    input  logic             loop_en,
    input  logic             start,
    input  logic             abort,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic             busy,
    output logic [IDX_W-1:0] step_idx,
    output logic             step_done,
    output logic             seq_done,
    output logic             err
);

    import nios_timer_seq_pkg::*;

    localparam logic [IDX_W:0]   c_depth   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   c_len_one = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

    seq_state_t       r_state, w_state_d;
    logic [IDX_W-1:0] r_idx, w_idx_d;
    logic [IDX_W:0]   r_len, w_len_d;
    logic             r_loop, w_loop_d;
    logic             r_err, w_err_d;
    logic             r_step_done, w_step_done_d;
    logic             r_seq_done, w_seq_done_d;
    logic             r_busy;
    tmr_bus_t         r_bus, w_bus_d;

    logic [31:0]      w_entry;
    logic             w_last;
    logic             w_abortable;
    logic [IDX_W:0]   w_len_clamped;
    logic             w_unused_rd;

    assign w_unused_rd = ^tmr_readdata[15:1];

    // The table is frozen for the whole run.
    nios_timer_seq_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .i_we    (cfg_we && (r_state == ST_IDLE)),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (w_idx_d),
        .o_rdata (w_entry)
    );

    assign w_len_clamped = (seq_len > c_depth) ? c_depth : seq_len;
    assign w_last        = ({1'b0, r_idx} == (r_len - c_len_one));
    assign w_abortable   = (r_state != ST_IDLE) && (r_state != ST_ABT_STOP) &&
                           (r_state != ST_ABT_CLR);

    // Next-state logic
    always_comb begin
        w_state_d     = r_state;
        w_idx_d       = r_idx;
        w_len_d       = r_len;
        w_loop_d      = r_loop;
        w_err_d       = r_err;
        w_step_done_d = 1'b0;
        w_seq_done_d  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err_d = 1'b0;
                    if (seq_len != '0) begin
                        w_state_d = ST_WR_PL;
                        w_idx_d   = '0;
                        w_len_d   = w_len_clamped;
                        w_loop_d  = loop_en;
                    end else begin
                        w_seq_done_d = 1'b1;
                    end
                end
            end
            ST_WR_PL:    w_state_d = ST_WR_PH;
            ST_WR_PH:    w_state_d = ST_WR_CTL;
            ST_WR_CTL:   w_state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (tmr_irq) begin
                    w_state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR:  w_state_d = ST_RD_CHK;
            ST_RD_CHK: begin
                // Read data from RD_ADDR arrives this cycle.
                if (!tmr_readdata[0]) begin
                    w_err_d = 1'b1;
                end
                w_state_d = ST_WR_CLR;
            end
            ST_WR_CLR: begin
                // Pulses are registered, so they are raised on entry to NEXT.
                w_state_d     = ST_NEXT;
                w_step_done_d = 1'b1;
                w_seq_done_d  = w_last && !r_loop;
            end
            ST_NEXT: begin
                if (w_last) begin
                    if (r_loop) begin
                        w_idx_d   = '0;
                        w_state_d = ST_WR_PL;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_idx_d   = r_idx + c_idx_one;
                    w_state_d = ST_WR_PL;
                end
            end
            ST_ABT_STOP: w_state_d = ST_ABT_CLR;
            ST_ABT_CLR:  w_state_d = ST_IDLE;
            default:     w_state_d = ST_IDLE;
        endcase

        // Abort wins over whatever the run would have done this cycle.
        if (abort && w_abortable) begin
            w_state_d     = ST_ABT_STOP;
            w_idx_d       = r_idx;
            w_err_d       = r_err;
            w_step_done_d = 1'b0;
            w_seq_done_d  = 1'b0;
        end
    end

    // Bus drive is decoded from the next state so the registered outputs
    // line up with the state that owns them.
    always_comb begin
        w_bus_d = BUS_IDLE;
        case (w_state_d)
            ST_WR_PL:    w_bus_d = bus_write(TMR_PERIODL, w_entry[15:0]);
            ST_WR_PH:    w_bus_d = bus_write(TMR_PERIODH, w_entry[31:16]);
            ST_WR_CTL:   w_bus_d = bus_write(TMR_CONTROL, CTL_START_ITO);
            ST_RD_ADDR: begin
                w_bus_d.cs   = 1'b1;
                w_bus_d.addr = TMR_STATUS;
            end
            ST_WR_CLR:   w_bus_d = bus_write(TMR_STATUS, 16'h0000);
            ST_ABT_STOP: w_bus_d = bus_write(TMR_CONTROL, CTL_STOP);
            ST_ABT_CLR:  w_bus_d = bus_write(TMR_STATUS, 16'h0000);
            default:     w_bus_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_err       <= 1'b0;
            r_step_done <= 1'b0;
            r_seq_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_bus       <= BUS_IDLE;
        end else begin
            r_state     <= w_state_d;
            r_idx       <= w_idx_d;
            r_len       <= w_len_d;
            r_loop      <= w_loop_d;
            r_err       <= w_err_d;
            r_step_done <= w_step_done_d;
            r_seq_done  <= w_seq_done_d;
            r_busy      <= (w_state_d != ST_IDLE);
            r_bus       <= w_bus_d;
        end
    end

    assign tmr_chipselect = r_bus.cs;
    assign tmr_write_n    = r_bus.write_n;
    assign tmr_address    = r_bus.addr;
    assign tmr_writedata  = r_bus.wdata;
    assign busy           = r_busy;
    assign step_idx       = r_idx;
    assign step_done      = r_step_done;
    assign seq_done       = r_seq_done;
    assign err            = r_err;

endmodule
`default_nettype wire
